// File: rtl/i2cmb_cmd_sequencer_if.sv
// Host request/response, engine command and status signals of the I2CMB command sequencer.
interface i2cmb_cmd_sequencer_if #(
  parameter int DATA_W  = 8,
  parameter int NUM_BUS = 16,
  parameter int DEPTH   = 8
);
  localparam int BUS_W = (NUM_BUS > 1) ? $clog2(NUM_BUS) : 1;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              req_valid_i;
  logic              req_ready_o;
  logic [2:0]        req_op_i;
  logic [DATA_W-1:0] req_data_i;
  logic [BUS_W-1:0]  req_bus_i;

  logic              eng_valid_o;
  logic              eng_ready_i;
  logic [2:0]        eng_op_o;
  logic [DATA_W-1:0] eng_data_o;
  logic [BUS_W-1:0]  eng_bus_o;
  logic              eng_done_i;
  logic [1:0]        eng_status_i;
  logic [DATA_W-1:0] eng_rdata_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [2:0]        rsp_op_o;
  logic [1:0]        rsp_status_o;
  logic [DATA_W-1:0] rsp_rdata_o;

  logic [LVL_W-1:0]  level_o;
  logic [7:0]        flush_cnt_o;

  modport slave (
    input  req_valid_i, req_op_i, req_data_i, req_bus_i,
           eng_ready_i, eng_done_i, eng_status_i, eng_rdata_i, rsp_ready_i,
    output req_ready_o, eng_valid_o, eng_op_o, eng_data_o, eng_bus_o,
           rsp_valid_o, rsp_op_o, rsp_status_o, rsp_rdata_o, level_o, flush_cnt_o
  );

  modport master (
    output req_valid_i, req_op_i, req_data_i, req_bus_i,
           eng_ready_i, eng_done_i, eng_status_i, eng_rdata_i, rsp_ready_i,
    input  req_ready_o, eng_valid_o, eng_op_o, eng_data_o, eng_bus_o,
           rsp_valid_o, rsp_op_o, rsp_status_o, rsp_rdata_o, level_o, flush_cnt_o
  );
endinterface

// File: rtl/i2cmb_cmd_sequencer.sv
// FIFO-fed command sequencer for the I2CMB byte engine with local bus-select handling.
// Optional flush-on-failure is enabled by defining I2CMB_SEQ_NAK_FLUSH_EN.
module i2cmb_cmd_sequencer #(
  parameter  int DATA_W  = 8,
  parameter  int DEPTH   = 8,
  parameter  int NUM_BUS = 16,
  localparam int BUS_W   = (NUM_BUS > 1) ? $clog2(NUM_BUS) : 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int LVL_W   = AW + 1
) (
  input  logic clk_i,
  input  logic rst_i,
  i2cmb_cmd_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;
  typedef struct packed {
    logic [2:0]        op;
    logic [DATA_W-1:0] data;
    logic [BUS_W-1:0]  bus;
  } cmd_t;

  localparam logic [2:0] OP_RDA = 3'd2, OP_RDN = 3'd3, OP_START = 3'd4,
                         OP_STOP = 3'd5, OP_SETBUS = 3'd6, OP_BAD = 3'd7;
  localparam logic [1:0] ST_OK = 2'd0, ST_NAK = 2'd1, ST_ARB = 2'd2, ST_ERR = 2'd3;
  localparam logic [BUS_W:0] NUM_BUS_L = (BUS_W+1)'(NUM_BUS);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  cmd_t              mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              rdy_q, rdy_d;
  state_t            state_q, state_d;
  logic [2:0]        cur_op_q, cur_op_d;
  logic [DATA_W-1:0] cur_data_q, cur_data_d;
  logic [BUS_W-1:0]  cur_bus_q, cur_bus_d;
  logic [1:0]        status_q, status_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              bus_open_q, bus_open_d;
  logic              push, pop, discard;
  cmd_t              head;
`ifdef I2CMB_SEQ_NAK_FLUSH_EN
  logic              flush_q, flush_d;
  logic [7:0]        flush_cnt_q, flush_cnt_d;
`endif

  assign head = mem_q[rd_ptr_q];
  assign push = bus.req_valid_i & rdy_q;

  always_ff @(posedge clk_i)
    if (push) mem_q[wr_ptr_q] <= '{op: bus.req_op_i, data: bus.req_data_i, bus: bus.req_bus_i};

  always_comb begin
    state_d    = state_q;
    cur_op_d   = cur_op_q;
    cur_data_d = cur_data_q;
    cur_bus_d  = cur_bus_q;
    status_d   = status_q;
    rdata_d    = rdata_q;
    bus_open_d = bus_open_q;
    pop        = 1'b0;
    discard    = 1'b0;
`ifdef I2CMB_SEQ_NAK_FLUSH_EN
    flush_d     = flush_q;
    flush_cnt_d = flush_cnt_q;
    // Failure-triggered flush drops everything up to the next START/STOP.
    discard = flush_q && (level_q != '0) && (head.op != OP_START) && (head.op != OP_STOP);
`endif
    case (state_q)
      IDLE: begin
`ifdef I2CMB_SEQ_NAK_FLUSH_EN
        if (!discard) flush_d = 1'b0;
`endif
        if (level_q != '0) begin
          pop = 1'b1;
          if (discard) begin
`ifdef I2CMB_SEQ_NAK_FLUSH_EN
            if (flush_cnt_q != 8'hFF) flush_cnt_d = flush_cnt_q + 8'd1;
`endif
          end else begin
            cur_op_d   = head.op;
            cur_data_d = head.data;
            status_d   = ST_OK;
            rdata_d    = '0;
            if (head.op == OP_BAD) begin
              status_d = ST_ERR;
              state_d  = RESP;
            end else if (head.op == OP_SETBUS) begin
              // Bus switching is refused while a transaction holds the bus.
              if (({1'b0, head.bus} >= NUM_BUS_L) || bus_open_q) status_d = ST_ERR;
              else cur_bus_d = head.bus;
              state_d = RESP;
            end else begin
              state_d = ISSUE;
            end
          end
        end
      end
      ISSUE: if (bus.eng_ready_i) state_d = WAIT_DONE;
      WAIT_DONE: if (bus.eng_done_i) begin
        status_d = bus.eng_status_i;
        rdata_d  = (cur_op_q == OP_RDA || cur_op_q == OP_RDN) ? bus.eng_rdata_i : '0;
        state_d  = RESP;
      end
      RESP: if (bus.rsp_ready_i) begin
        state_d = IDLE;
        if (cur_op_q == OP_START && status_q == ST_OK) bus_open_d = 1'b1;
        if (cur_op_q == OP_STOP  && status_q == ST_OK) bus_open_d = 1'b0;
        if (status_q == ST_ARB) bus_open_d = 1'b0;
`ifdef I2CMB_SEQ_NAK_FLUSH_EN
        if (status_q == ST_NAK || status_q == ST_ARB) flush_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
    rdy_d = (level_d < DEPTH_L);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rdy_q      <= 1'b0;
      state_q    <= IDLE;
      cur_op_q   <= '0;
      cur_data_q <= '0;
      cur_bus_q  <= '0;
      status_q   <= '0;
      rdata_q    <= '0;
      bus_open_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rdy_q      <= rdy_d;
      state_q    <= state_d;
      cur_op_q   <= cur_op_d;
      cur_data_q <= cur_data_d;
      cur_bus_q  <= cur_bus_d;
      status_q   <= status_d;
      rdata_q    <= rdata_d;
      bus_open_q <= bus_open_d;
    end
  end

`ifdef I2CMB_SEQ_NAK_FLUSH_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flush_q     <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      flush_q     <= flush_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign bus.flush_cnt_o = flush_cnt_q;
`else
  assign bus.flush_cnt_o = '0;
`endif

  assign bus.req_ready_o  = rdy_q;
  assign bus.eng_valid_o  = (state_q == ISSUE);
  assign bus.eng_op_o     = cur_op_q;
  assign bus.eng_data_o   = cur_data_q;
  assign bus.eng_bus_o    = cur_bus_q;
  assign bus.rsp_valid_o  = (state_q == RESP);
  assign bus.rsp_op_o     = cur_op_q;
  assign bus.rsp_status_o = status_q;
  assign bus.rsp_rdata_o  = rdata_q;
  assign bus.level_o      = level_q;
endmodule
